// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states, access op, default widths.
package sdram_arb_pkg;

    localparam int DEF_ADDR_W = 23;
    localparam int DEF_DATA_W = 32;
    localparam int GRANT_W    = 3;   // grant_id width, covers up to 8 requesters

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DATA,
        DONE
    } arb_state_e;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } arb_op_e;

endpackage

// File: rtl/sdram_arbiter_rr_pick.sv
// Combinational round-robin picker: first active index after last_grant, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_REQ-1:0] active,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    int cand;

    // Scan last_grant+1, +2, ... +NUM_REQ (mod NUM_REQ); the first hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && cand == i && active[i]) begin
                    found = 1'b1;
                    idx   = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Serialises NUM_REQ read/write/finished requesters onto one Avalon-style SDRAM port.
// One access in flight, round-robin grant, watchdog on read data return.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             req_read,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_writedata,
    output logic [DATA_W-1:0]              req_readdata,
    output logic [NUM_REQ-1:0]             req_finished,
    output logic [ADDR_W-1:0]              sdram_address,
    output logic                           sdram_read,
    output logic                           sdram_write,
    output logic [DATA_W-1:0]              sdram_writedata,
    input  logic [DATA_W-1:0]              sdram_readdata,
    input  logic                           sdram_readdatavalid,
    input  logic                           sdram_waitrequest,
    output logic [GRANT_W-1:0]             grant_id,
    output logic                           busy,
    output logic                           timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    arb_state_e          state_q, state_d;
    arb_op_e             op_q, op_d;
    logic [GRANT_W-1:0]  id_q, id_d;
    logic [GRANT_W-1:0]  last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                terr_q, terr_d;
    logic [NUM_REQ-1:0]  fin_q, fin_d;

    logic                pick_found;
    logic [GRANT_W-1:0]  pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (GRANT_W)
    ) u_rr_pick (
        .active     (req_read | req_write),
        .last_grant (last_q),
        .found      (pick_found),
        .idx        (pick_idx)
    );

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            op_q    <= OP_READ;
            id_q    <= '0;
            last_q  <= GRANT_W'(NUM_REQ - 1);
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wd_q    <= '0;
            terr_q  <= 1'b0;
            fin_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            id_q    <= id_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wd_q    <= wd_d;
            terr_q  <= terr_d;
            fin_q   <= fin_d;
        end
    end

    // Next-state: grant in IDLE, hold strobe through stalls, wait for data or watchdog.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        id_d    = id_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wd_d    = wd_q;
        terr_d  = terr_q;
        fin_d   = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    id_d    = pick_idx;
                    state_d = ISSUE;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (pick_idx == GRANT_W'(i)) begin
                            // write wins when a requester raises both
                            op_d    = req_write[i] ? OP_WRITE : OP_READ;
                            addr_d  = req_addr[i];
                            wdata_d = req_writedata[i];
                        end
                    end
                end
            end
            ISSUE: begin
                if (!sdram_waitrequest) begin
                    if (op_q == OP_WRITE) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT_DATA;
                        wd_d    = '0;
                    end
                end
            end
            WAIT_DATA: begin
                if (sdram_readdatavalid) begin
                    rdata_d = sdram_readdata;
                    state_d = DONE;
                end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    // this cycle is the TIMEOUT_CYC-th spent waiting
                    rdata_d = '0;
                    terr_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            DONE: begin
                last_d  = id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // finished is registered so it is high exactly during the DONE cycle
        if (state_d == DONE) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                fin_d[i] = (id_d == GRANT_W'(i));
            end
        end
    end

    assign sdram_read      = (state_q == ISSUE) && (op_q == OP_READ);
    assign sdram_write     = (state_q == ISSUE) && (op_q == OP_WRITE);
    assign sdram_address   = addr_q;
    assign sdram_writedata = wdata_q;
    assign req_readdata    = rdata_q;
    assign req_finished    = fin_q;
    assign grant_id        = id_q;
    assign busy            = (state_q != IDLE);
    assign timeout_err     = terr_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scenario bench for sdram_arbiter: tasks drive requesters, a scoreboard checks completions.
`timescale 1ns/1ps
module tb_sdram_arbiter;

    localparam int N   = 3;
    localparam int AW  = 23;
    localparam int DW  = 32;
    localparam int TMO = 60;

    logic                   i_clk = 1'b0;
    logic                   i_rst = 1'b1;
    logic [N-1:0]           req_read = '0;
    logic [N-1:0]           req_write = '0;
    logic [N-1:0][AW-1:0]   req_addr = '0;
    logic [N-1:0][DW-1:0]   req_writedata = '0;
    logic [DW-1:0]          req_readdata;
    logic [N-1:0]           req_finished;
    logic [AW-1:0]          sdram_address;
    logic                   sdram_read;
    logic                   sdram_write;
    logic [DW-1:0]          sdram_writedata;
    logic [DW-1:0]          sdram_readdata = 32'hBAD0BAD0;
    logic                   sdram_readdatavalid = 1'b0;
    logic                   sdram_waitrequest = 1'b0;
    logic [2:0]             grant_id;
    logic                   busy;
    logic                   timeout_err;

    sdram_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_writedata(req_writedata),
        .req_readdata(req_readdata), .req_finished(req_finished),
        .sdram_address(sdram_address), .sdram_read(sdram_read),
        .sdram_write(sdram_write), .sdram_writedata(sdram_writedata),
        .sdram_readdata(sdram_readdata), .sdram_readdatavalid(sdram_readdatavalid),
        .sdram_waitrequest(sdram_waitrequest),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [31:0] data;   // req_readdata expected in the finished cycle
    } exp_t;
    exp_t sb_q[$];

    int          errors = 0;
    int          checks = 0;
    logic [31:0] rd_model = '0;

    // Controller model: data for an accepted read arrives the following cycle.
    function automatic logic [31:0] rd_val(input logic [AW-1:0] a);
        return 32'hDEADBEEF ^ {9'd0, a} ^ 32'h0000_0100;
    endfunction

    logic        rsp_en = 1'b1;
    logic        pend = 1'b0;
    logic [31:0] pend_data = '0;
    always @(negedge i_clk) begin
        sdram_readdatavalid = 1'b0;
        sdram_readdata      = 32'hBAD0BAD0;
        if (pend) begin
            sdram_readdatavalid = 1'b1;
            sdram_readdata      = pend_data;
            pend                = 1'b0;
        end
        if (i_rst) pend = 1'b0;
        else if (sdram_read && !sdram_waitrequest && rsp_en) begin
            pend      = 1'b1;
            pend_data = rd_val(sdram_address);
        end
    end

    // Scoreboard consumer: every finished pulse pops one expected completion.
    task automatic monitor();
        exp_t         e;
        logic [N-1:0] oh;
        forever begin
            @(negedge i_clk);
            if (req_finished != '0) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_finish: got %b with nothing outstanding", req_finished);
                end else begin
                    e = sb_q.pop_front();
                    oh = '0;
                    oh[e.id] = 1'b1;
                    if (req_finished !== oh) begin
                        errors++;
                        $display("FAIL sb_finished: got %b want %b", req_finished, oh);
                    end
                    checks++;
                    if (req_readdata !== e.data) begin
                        errors++;
                        $display("FAIL sb_readdata: got %h want %h", req_readdata, e.data);
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge i_clk);
            if (req_finished != '0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_done: no finished pulse within %0d cycles", budget);
        end
    endtask

    task automatic do_reset();
        req_read = '0; req_write = '0; rsp_en = 1'b1; sdram_waitrequest = 1'b0;
        step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge i_clk);
        checks++;
        if ({busy, sdram_read, sdram_write, timeout_err, req_finished, grant_id} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0",
                     {busy, sdram_read, sdram_write, timeout_err, req_finished, grant_id});
        end
        checks++;
        if (sdram_address !== '0) begin
            errors++; $display("FAIL reset_addr: got %h want 0", sdram_address);
        end
        checks++;
        if (req_readdata !== '0 || sdram_writedata !== '0) begin
            errors++; $display("FAIL reset_data: got %h/%h want 0", req_readdata, sdram_writedata);
        end
        step();
        i_rst = 1'b0;
    endtask

    task automatic test_single_read();
        int c0;
        step();
        c0 = cyc;
        req_addr[0] = 23'h000100;
        req_read[0] = 1'b1;
        sb_q.push_back('{0, 32'hDEADBEEF});
        rd_model = 32'hDEADBEEF;
        @(negedge i_clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL read_c0_busy: got %b want 0", busy); end
        @(negedge i_clk);
        checks++;
        if (sdram_read !== 1'b1 || sdram_address !== 23'h000100) begin
            errors++;
            $display("FAIL read_issue: read=%b addr=%h want 1/000100", sdram_read, sdram_address);
        end
        wait_done(10);
        checks++;
        if (cyc - c0 != 3) begin errors++; $display("FAIL read_latency: got %0d want 3", cyc - c0); end
        step();
        req_read[0] = 1'b0;
    endtask

    task automatic test_write_stall();
        int c0;
        step();
        c0 = cyc;
        sdram_waitrequest = 1'b1;
        req_addr[1]      = 23'h0002A0;
        req_writedata[1] = 32'h12345678;
        req_write[1]     = 1'b1;
        sb_q.push_back('{1, rd_model});
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 5) sdram_waitrequest = 1'b0;
            @(negedge i_clk);
            checks++;
            if (sdram_write !== 1'b1 || sdram_address !== 23'h0002A0 || sdram_writedata !== 32'h12345678) begin
                errors++;
                $display("FAIL write_hold_c%0d: wr=%b addr=%h data=%h", k, sdram_write, sdram_address, sdram_writedata);
            end
        end
        wait_done(10);
        checks++;
        if (cyc - c0 != 6) begin errors++; $display("FAIL write_latency: got %0d want 6", cyc - c0); end
        checks++;
        if (sdram_write !== 1'b0) begin errors++; $display("FAIL write_drop: got %b want 0", sdram_write); end
        step();
        req_write[1] = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] a;
        do_reset();
        for (int i = 0; i < N; i++) req_addr[i] = AW'(32'h10 * (i + 1));
        for (int t = 0; t < 6; t++) begin
            a = req_addr[t % N];
            sb_q.push_back('{t % N, rd_val(a)});
        end
        req_read = '1;
        for (int t = 0; t < 6; t++) begin
            wait_done(20);
            checks++;
            if (grant_id !== 3'(t % N)) begin
                errors++; $display("FAIL rr_order_%0d: got %0d want %0d", t, grant_id, t % N);
            end
        end
        step();
        req_read = '0;
        a = req_addr[N-1];
        rd_model = rd_val(a);
    endtask

    task automatic test_conflict();
        logic saw_rd, saw_wr;
        bit   done;
        saw_rd = 1'b0; saw_wr = 1'b0; done = 1'b0;
        step();
        req_addr[2]      = 23'h00003F;
        req_writedata[2] = 32'hCAFEF00D;
        req_read[2]      = 1'b1;
        req_write[2]     = 1'b1;
        sb_q.push_back('{2, rd_model});
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge i_clk);
            saw_rd |= sdram_read;
            saw_wr |= sdram_write;
            done = (req_finished != '0);
        end
        checks++;
        if (saw_rd !== 1'b0 || saw_wr !== 1'b1) begin
            errors++; $display("FAIL conflict_op: read=%b write=%b want 0/1", saw_rd, saw_wr);
        end
        step();
        req_read[2] = 1'b0; req_write[2] = 1'b0;
    endtask

    task automatic test_watchdog();
        int c0;
        step();
        rsp_en = 1'b0;
        c0 = cyc;
        req_addr[0] = 23'h000055;
        req_read[0] = 1'b1;
        sb_q.push_back('{0, 32'h0});
        rd_model = '0;
        wait_done(TMO + 20);
        checks++;
        if (cyc - c0 != TMO + 2) begin errors++; $display("FAIL wd_latency: got %0d want %0d", cyc - c0, TMO + 2); end
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_flag: got %b want 1", timeout_err); end
        step();
        req_read[0] = 1'b0;
        repeat (5) step();
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %b want 1", timeout_err); end
    endtask

    task automatic test_reset_mid_read();
        logic [AW-1:0] a;
        step();
        rsp_en = 1'b0;
        req_addr[1] = 23'h000077;
        req_read[1] = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++;
        if (busy !== 1'b1 || sdram_read !== 1'b0) begin
            errors++; $display("FAIL mid_wait_state: busy=%b read=%b want 1/0", busy, sdram_read);
        end
        step();
        i_rst = 1'b1;
        req_read = '0;
        #1;
        checks++;
        if ({busy, sdram_read, sdram_write, timeout_err, req_finished, grant_id} !== '0) begin
            errors++;
            $display("FAIL mid_reset_ctrl: got %b want 0",
                     {busy, sdram_read, sdram_write, timeout_err, req_finished, grant_id});
        end
        checks++;
        if (sdram_address !== '0 || req_readdata !== '0) begin
            errors++; $display("FAIL mid_reset_data: addr=%h rd=%h want 0", sdram_address, req_readdata);
        end
        step();
        i_rst = 1'b0;
        repeat (4) @(negedge i_clk);
        rsp_en = 1'b1;
        step();
        req_addr[0] = 23'h000011;
        req_addr[1] = 23'h000012;
        a = req_addr[0]; sb_q.push_back('{0, rd_val(a)});
        a = req_addr[1]; sb_q.push_back('{1, rd_val(a)});
        req_read[0] = 1'b1;
        req_read[1] = 1'b1;
        wait_done(20);
        checks++;
        if (grant_id !== 3'd0) begin errors++; $display("FAIL post_reset_first: got %0d want 0", grant_id); end
        wait_done(20);
        checks++;
        if (grant_id !== 3'd1) begin errors++; $display("FAIL post_reset_second: got %0d want 1", grant_id); end
        step();
        req_read = '0;
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single_read();
        test_write_stall();
        test_round_robin();
        test_conflict();
        test_watchdog();
        test_reset_mid_read();
        repeat (3) step();
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL sb_drain: %0d completions outstanding", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

endmodule
